seq_pattern_detector: RTL and testbench

//  Parametrised serial pattern detector: successor to the fixed 3-state input FSMs in the accumulator path.

---
 rtl/seq_pattern_detector_pkg.sv | 24 ++
 rtl/sat_counter.sv | 49 ++++
 rtl/seq_pattern_detector.sv | 106 ++++++++++
 tb/tb_seq_pattern_detector.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pattern_detector_pkg.sv
// seq_pattern_detector_pkg: shared state encoding, default pattern and legal parameter ranges.
`default_nettype none

package seq_pattern_detector_pkg;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  localparam logic [3:0] c_DEFAULT_PAT = 4'b1011;

  localparam int c_PAT_W_MIN = 2;
  localparam int c_PAT_W_MAX = 16;
  localparam int c_CNT_W_MIN = 2;
  localparam int c_CNT_W_MAX = 16;

  function automatic bit in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with sticky saturation flag; clear takes effect before increment.
`default_nettype none

module sat_counter
  import seq_pattern_detector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic             sat
);

  localparam logic [WIDTH-1:0] c_MAX = '1;

  if (!in_range(WIDTH, c_CNT_W_MIN, c_CNT_W_MAX)) begin : g_bad_width
    $error("sat_counter: WIDTH outside legal range 2..16");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = clr ? '0 : cnt_q;
    if (inc && (cnt_d != c_MAX)) begin
      cnt_d = cnt_d + WIDTH'(1);
    end
    sat_d = (sat_q && !clr) || (cnt_d == c_MAX);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign q   = cnt_q;
  assign sat = sat_q;

endmodule

`default_nettype wire

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: serial pattern matcher with loadable pattern, overlap select and
// saturating match count (rev 1.0).
`default_nettype none

module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int               PAT_W       = 4,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(c_DEFAULT_PAT)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             filled
);

  localparam int               FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] c_FULL = FILL_W'(PAT_W);

  if (!in_range(PAT_W, c_PAT_W_MIN, c_PAT_W_MAX)) begin : g_bad_pat_w
    $error("seq_pattern_detector: PAT_W outside legal range 2..16");
  end

  // Only PAT_W-1 bits are kept: the compare always uses the incoming bit as the newest one.
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  state_e            state_q, state_d;
  logic              match_q;

  logic [PAT_W-1:0]  hist_next;
  logic [FILL_W-1:0] fill_next;
  logic              hit;

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    state_d   = state_q;
    hist_next = {hist_q, in_bit};
    fill_next = (fill_q == c_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit       = in_valid && !pat_load && (fill_next == c_FULL) && (hist_next == pat_q);

    if (pat_load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = S_FILL;
    end else if (in_valid) begin
      hist_d = hist_next[PAT_W-2:0];
      fill_d = fill_next;
      case (state_q)
        S_FILL:  if (fill_next == c_FULL) state_d = S_SCAN;
        S_SCAN:  state_d = S_SCAN;
        default: state_d = S_FILL;
      endcase
      if (hit && !overlap) begin
        hist_d  = '0;
        fill_d  = '0;
        state_d = S_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEFAULT_PAT;
      state_q <= S_FILL;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      state_q <= state_d;
      match_q <= hit;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .clr_n(clr_n),
    .inc  (hit),
    .clr  (clr_cnt),
    .q    (match_cnt),
    .sat  (cnt_sat)
  );

  assign match  = match_q;
  assign filled = (state_q == S_SCAN);

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: directed scenarios plus random stream against a queue-based reference model.
`default_nettype none

module tb_seq_pattern_detector;

  localparam int PAT_W = 4;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             in_valid, in_bit, overlap, pat_load, clr_cnt;
  logic [PAT_W-1:0] pat_in;

  logic       match, filled, cnt_sat;
  logic [7:0] match_cnt;
  logic       match2, filled2, cnt_sat2;
  logic [1:0] match_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: recent accepted bits, current pattern, counters as plain integers.
  bit         mq[$];
  logic [3:0] m_pat;
  bit         m_match;
  int         m_cnt8, m_cnt2;
  bit         m_sat8, m_sat2;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .match(match), .match_cnt(match_cnt), .cnt_sat(cnt_sat), .filled(filled)
  );

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) u_dut2 (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_bit(in_bit), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_cnt(clr_cnt),
    .match(match2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2), .filled(filled2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int q_value();
    int v = 0;
    foreach (mq[i]) v = v * 2 + int'(mq[i]);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pat   = 4'b1011;
    m_match = 1'b0;
    m_cnt8  = 0;
    m_cnt2  = 0;
    m_sat8  = 1'b0;
    m_sat2  = 1'b0;
  endtask

  task automatic model_edge();
    m_match = 1'b0;
    if (pat_load) begin
      m_pat = pat_in;
      mq.delete();
    end else if (in_valid) begin
      mq.push_back(in_bit);
      if (mq.size() > PAT_W) void'(mq.pop_front());
      if (mq.size() == PAT_W && q_value() == int'(m_pat)) begin
        m_match = 1'b1;
        if (!overlap) mq.delete();
      end
    end
    if (clr_cnt) begin
      m_cnt8 = 0; m_sat8 = 1'b0;
      m_cnt2 = 0; m_sat2 = 1'b0;
    end
    if (m_match) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    if (m_cnt8 == 255) m_sat8 = 1'b1;
    if (m_cnt2 == 3) m_sat2 = 1'b1;
  endtask

  task automatic check_all(input string pfx);
    bit exp_filled = (mq.size() >= PAT_W);
    check_eq({pfx, ".match"},   32'(match),      32'(m_match));
    check_eq({pfx, ".filled"},  32'(filled),     32'(exp_filled));
    check_eq({pfx, ".cnt8"},    32'(match_cnt),  32'(m_cnt8));
    check_eq({pfx, ".sat8"},    32'(cnt_sat),    32'(m_sat8));
    check_eq({pfx, ".match2"},  32'(match2),     32'(m_match));
    check_eq({pfx, ".filled2"}, 32'(filled2),    32'(exp_filled));
    check_eq({pfx, ".cnt2"},    32'(match_cnt2), 32'(m_cnt2));
    check_eq({pfx, ".sat2"},    32'(cnt_sat2),   32'(m_sat2));
  endtask

  task automatic step(input logic v, input logic b, input logic ovl, input logic ld,
                      input logic [3:0] pin, input logic clr);
    in_valid = v; in_bit = b; overlap = ovl; pat_load = ld; pat_in = pin; clr_cnt = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all("step");
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = '0; clr_cnt = 1'b0;
    clr_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    clr_n = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input logic ovl);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ovl, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    logic ovl_r;
    do_reset();

    // Non-overlapping: only the first 1011 hits
    send_bits(32'b1011011, 7, 1'b0);
    check_eq("t1_cnt", 32'(match_cnt), 32'd1);
    check_eq("t1_filled", 32'(filled), 32'd0);

    do_reset();
    send_bits(32'b1011011, 7, 1'b1);
    check_eq("t2_cnt", 32'(match_cnt), 32'd2);

    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("t3_match", 32'(match), 32'd1);

    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0);
    check_eq("t4_load_match", 32'(match), 32'd0);
    send_bits(32'b0110, 4, 1'b0);
    check_eq("t4_match", 32'(match), 32'd1);

    do_reset();
    send_bits(32'b1011011011011011, 16, 1'b1);
    check_eq("t5_cnt2", 32'(match_cnt2), 32'd3);
    check_eq("t5_sat2", 32'(cnt_sat2), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    check_eq("t5_clr_cnt2", 32'(match_cnt2), 32'd1);
    check_eq("t5_clr_sat2", 32'(cnt_sat2), 32'd0);
    check_eq("t5_clr_cnt8", 32'(match_cnt), 32'd1);

    do_reset();
    send_bits(32'b101, 3, 1'b0);
    do_reset();
    send_bits(32'b1, 1, 1'b0);
    check_eq("t6_match", 32'(match), 32'd0);
    check_eq("t6_filled", 32'(filled), 32'd0);
    check_eq("t6_cnt", 32'(match_cnt), 32'd0);

    // Random stream with occasional pattern loads, counter clears, overlap flips and resets
    do_reset();
    ovl_r = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      int r = int'($urandom_range(0, 999));
      if (i % 97 == 0) ovl_r = 1'($urandom_range(0, 1));
      if (r < 3) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), ovl_r,
             1'(r < 25), 4'($urandom_range(0, 15)), 1'(r >= 990));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
